// File: rtl/audio_player_if.sv
// rtl/audio_player_if.sv - control, ROM and audio signal bundle for audio_player
interface audio_player_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [15:0]       sample;
    logic              sample_valid;
    logic              busy;
    logic              done;
    logic              audio_out;

    modport master (
        output start, stop, rom_data,
        input  rom_addr, sample, sample_valid, busy, done, audio_out
    );

    modport slave (
        input  start, stop, rom_data,
        output rom_addr, sample, sample_valid, busy, done, audio_out
    );
endinterface

// File: rtl/audio_player.sv
// rtl/audio_player.sv - ROM sample playback with phase-accumulator tick and sigma-delta output
// Define AUDIO_LOOP_EN to wrap to address 0 at end of clip instead of stopping.
module audio_player #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SAMPLE_HZ   = 44100,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned NUM_SAMPLES = 176400
) (
    input  logic           clk,
    input  logic           rst,
    audio_player_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PLAY, FETCH, CAPTURE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

    state_t            state_q, state_d;
    logic [31:0]       acc_q, acc_d;
    logic              tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       sample_q, sample_d;
    logic              sv_q, sv_d;
    logic              done_q, done_d;
    logic [16:0]       sd_q, sd_d;
    logic [32:0]       phase_sum;
    logic              last;

    assign phase_sum = {1'b0, acc_q} + 33'(SAMPLE_HZ);
    assign last      = (addr_q == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // stop outranks start; start outranks everything the FSM would otherwise do
    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = IDLE;
        end else if (bus.start) begin
            state_d = PLAY;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                PLAY:    if (tick_q) state_d = FETCH;
                FETCH:   state_d = CAPTURE;
`ifdef AUDIO_LOOP_EN
                CAPTURE: state_d = PLAY;
`else
                CAPTURE: state_d = last ? IDLE : PLAY;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d    = acc_q;
        tick_d   = 1'b0;
        addr_d   = addr_q;
        sample_d = done_q ? 16'h0000 : sample_q;
        sv_d     = 1'b0;
        done_d   = 1'b0;
        bus.busy = (state_q != IDLE);
        if (bus.stop) begin
            acc_d    = '0;
            addr_d   = '0;
            sample_d = 16'h0000;
        end else if (bus.start) begin
            acc_d  = '0;
            addr_d = '0;
        end else begin
            if (state_q != IDLE) begin
                if (phase_sum >= 33'(CLK_HZ)) begin
                    acc_d  = phase_sum[31:0] - 32'(CLK_HZ);
                    tick_d = 1'b1;
                end else begin
                    acc_d  = phase_sum[31:0];
                end
            end
            if (state_q == CAPTURE) begin
                sample_d = bus.rom_data;
                sv_d     = 1'b1;
                if (last) begin
                    addr_d = '0;
`ifndef AUDIO_LOOP_EN
                    done_d = 1'b1;
`endif
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            tick_q   <= 1'b0;
            addr_q   <= '0;
            sample_q <= 16'h0000;
            sv_q     <= 1'b0;
            done_q   <= 1'b0;
            sd_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            tick_q   <= tick_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            sv_q     <= sv_d;
            done_q   <= done_d;
            sd_q     <= sd_d;
        end
    end

    // offset-binary input so a zero sample gives a 50% duty bitstream
    assign sd_d = {1'b0, sd_q[15:0]} + {1'b0, ~sample_q[15], sample_q[14:0]};

    assign bus.rom_addr     = addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = sv_q;
    assign bus.done         = done_q;
    assign bus.audio_out    = sd_q[16];
endmodule

// File: tb/tb_audio_player.sv
// tb/tb_audio_player.sv - directed self-checking bench for audio_player
module tb_audio_player;
    logic clk;
    logic rst;
    logic [15:0] sd_val;
    int checks;
    int errors;

    audio_player_if #(.ADDR_W(18)) bus1 ();
    audio_player_if #(.ADDR_W(18)) bus2 ();

    audio_player #(
        .CLK_HZ(441000), .SAMPLE_HZ(44100), .ADDR_W(18), .NUM_SAMPLES(4)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    audio_player #(
        .CLK_HZ(441000), .SAMPLE_HZ(44100), .ADDR_W(18), .NUM_SAMPLES(176400)
    ) dut_sd (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus1.rom_data <= bus1.rom_addr[15:0];
        bus2.rom_data <= sd_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic s, input logic p);
        bus1.start = s;
        bus1.stop  = p;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.stop  = 1'b0;
    endtask

    task automatic wait_sv(output int k);
        int n;
        n = 0;
        k = -1;
        while (k < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus1.sample_valid) k = n;
        end
    endtask

    task automatic wait_sv2(output int k);
        int n;
        n = 0;
        k = -1;
        while (k < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus2.sample_valid) k = n;
        end
    endtask

    task automatic count_events(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus1.sample_valid || bus1.done) cnt++;
        end
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus2.audio_out) ones++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_addr"}, 32'(bus1.rom_addr), 0);
        chk({tag, "_sample"}, 32'(bus1.sample), 0);
        chk({tag, "_sample_valid"}, 32'(bus1.sample_valid), 0);
        chk({tag, "_busy"}, 32'(bus1.busy), 0);
        chk({tag, "_done"}, 32'(bus1.done), 0);
        chk({tag, "_audio_out"}, 32'(bus1.audio_out), 0);
    endtask

    initial begin
        int k;
        int cnt;
        int ones;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sd_val = 16'h0000;
        bus1.start = 1'b0;
        bus1.stop  = 1'b0;
        bus2.start = 1'b0;
        bus2.stop  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // clip of 4 samples, one tick every 10 cycles
        pulse(1'b1, 1'b0);
        wait_sv(k);
        chk("first_latency", 32'(k), 13);
        chk("first_sample", 32'(bus1.sample), 0);
        chk("first_addr", 32'(bus1.rom_addr), 1);
        chk("first_busy", 32'(bus1.busy), 1);
        for (int i = 1; i < 4; i++) begin
            wait_sv(k);
            chk("period", 32'(k), 10);
            chk("seq_sample", 32'(bus1.sample), 32'(i));
            if (i < 3) begin
                chk("seq_addr", 32'(bus1.rom_addr), 32'(i + 1));
                chk("seq_done", 32'(bus1.done), 0);
            end
        end
`ifdef AUDIO_LOOP_EN
        chk("loop_done", 32'(bus1.done), 0);
        chk("loop_busy", 32'(bus1.busy), 1);
        chk("loop_addr", 32'(bus1.rom_addr), 0);
        @(negedge clk);
        chk("loop_sv_width", 32'(bus1.sample_valid), 0);
        chk("loop_hold", 32'(bus1.sample), 3);
        wait_sv(k);
        chk("loop_period", 32'(k), 10);
        chk("loop_wrap_sample", 32'(bus1.sample), 0);
        chk("loop_wrap_done", 32'(bus1.done), 0);
        pulse(1'b0, 1'b1);
        chk("stop_busy", 32'(bus1.busy), 0);
        chk("stop_sample", 32'(bus1.sample), 0);
        chk("stop_addr", 32'(bus1.rom_addr), 0);
`else
        chk("end_done", 32'(bus1.done), 1);
        chk("end_busy", 32'(bus1.busy), 0);
        chk("end_addr", 32'(bus1.rom_addr), 0);
        @(negedge clk);
        chk("end_sample_clear", 32'(bus1.sample), 0);
        chk("end_done_width", 32'(bus1.done), 0);
        chk("end_sv_width", 32'(bus1.sample_valid), 0);
        count_events(30, cnt);
        chk("end_idle_quiet", 32'(cnt), 0);
`endif

        // start and stop together while playing: stop wins
        pulse(1'b1, 1'b0);
        wait_sv(k);
        wait_sv(k);
        chk("ss_pre_sample", 32'(bus1.sample), 1);
        pulse(1'b1, 1'b1);
        chk("ss_busy", 32'(bus1.busy), 0);
        chk("ss_sample", 32'(bus1.sample), 0);
        chk("ss_addr", 32'(bus1.rom_addr), 0);
        count_events(30, cnt);
        chk("ss_no_events", 32'(cnt), 0);

        // restart issued while in FETCH discards the pending capture
        pulse(1'b1, 1'b0);
        wait_sv(k);
        wait_sv(k);
        chk("rs_pre_addr", 32'(bus1.rom_addr), 2);
        repeat (8) @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_sv(k);
        chk("rs_latency", 32'(k), 13);
        chk("rs_sample", 32'(bus1.sample), 0);
        chk("rs_addr", 32'(bus1.rom_addr), 1);

        // asynchronous reset while in FETCH
        wait_sv(k);
        chk("rst_pre_sample", 32'(bus1.sample), 1);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        count_events(25, cnt);
        chk("midrst_quiet", 32'(cnt), 0);
        chk("midrst_busy", 32'(bus1.busy), 0);

        // sigma-delta density over 4096 cycles with the sample held
        sd_val = 16'h7FFF;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_sv2(k);
        chk("sd_7fff_sample", 32'(bus2.sample), 32'h7FFF);
        count_ones(4096, ones);
        chk("sd_7fff_ones", 32'(ones >= 4095 && ones <= 4097), 1);
        sd_val = 16'h8000;
        wait_sv2(k);
        chk("sd_8000_sample", 32'(bus2.sample), 32'h8000);
        count_ones(4096, ones);
        chk("sd_8000_ones", 32'(ones <= 1), 1);
        sd_val = 16'h0000;
        wait_sv2(k);
        chk("sd_0000_sample", 32'(bus2.sample), 0);
        count_ones(4096, ones);
        chk("sd_0000_ones", 32'(ones >= 2047 && ones <= 2049), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
